// File: rtl/svi_array_driver.sv
// Rotating-pattern driver for an array of x/y interface lanes, with sampler echo checking.
// Optional echo checker: compiled in when SVI_DRV_CHECK_EN is defined.
module svi_array_driver #(
  parameter int unsigned N_LANES = 8,
  parameter int unsigned PAT_W   = 8,
  parameter int unsigned LEN_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [PAT_W-1:0]   i_pat_x,
  input  logic [PAT_W-1:0]   i_pat_y,
  input  logic [LEN_W-1:0]   i_len,
  output logic [N_LANES-1:0] o_x,
  output logic [N_LANES-1:0] o_y,
  output logic               o_busy,
  output logic               o_done,
  input  logic [N_LANES-1:0] i_a,
  input  logic [N_LANES-1:0] i_b,
  output logic               o_err,
  output logic [LEN_W-1:0]   o_err_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, FLUSH, DONE} state_t;

  state_t           state;
  logic [PAT_W-1:0] rx;
  logic [PAT_W-1:0] ry;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat;
  logic             drive_v;

  function automatic logic [PAT_W-1:0] rotr(input logic [PAT_W-1:0] v);
    return {v[0], v[PAT_W-1:1]};
  endfunction

  // Lane k takes rotation bit (k mod PAT_W).
  function automatic logic [N_LANES-1:0] lanes(input logic [PAT_W-1:0] v);
    logic [N_LANES-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N_LANES; k++) r[k] = v[k % PAT_W];
    return r;
  endfunction

  // Sequencer; rx/ry always hold the pattern of the beat currently on o_x/o_y.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      rx      <= '0;
      ry      <= '0;
      len_q   <= '0;
      beat    <= '0;
      drive_v <= 1'b0;
      o_x     <= '0;
      o_y     <= '1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            len_q <= i_len;
            beat  <= '0;
            rx    <= i_pat_x;
            ry    <= i_pat_y;
            if (i_len == '0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state   <= DRIVE;
              o_busy  <= 1'b1;
              drive_v <= 1'b1;
              o_x     <= lanes(i_pat_x);
              o_y     <= lanes(i_pat_y);
            end
          end
        end
        DRIVE: begin
          if (beat == len_q - LEN_W'(1)) begin
            state   <= FLUSH;
            drive_v <= 1'b0;
            o_x     <= '0;
            o_y     <= '1;
          end else begin
            beat <= beat + LEN_W'(1);
            rx   <= rotr(rx);
            ry   <= rotr(ry);
            o_x  <= lanes(rotr(rx));
            o_y  <= lanes(rotr(ry));
          end
        end
        FLUSH: begin
          state  <= DONE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SVI_DRV_CHECK_EN
  logic [N_LANES-1:0] exp_x;
  logic [N_LANES-1:0] exp_y;
  logic               chk_v;

  // Echo of a beat arrives one cycle after it was driven; compare against a delayed copy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_x     <= '0;
      exp_y     <= '1;
      chk_v     <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      exp_x <= o_x;
      exp_y <= o_y;
      chk_v <= drive_v;
      if (state == IDLE && i_start) begin
        o_err     <= 1'b0;
        o_err_cnt <= '0;
      end else if (chk_v && ((i_a != exp_x) || (i_b != exp_y))) begin
        o_err <= 1'b1;
        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + LEN_W'(1);
      end
    end
  end
`else
  logic unused_echo;
  assign unused_echo = ^{i_a, i_b};
  assign o_err       = 1'b0;
  assign o_err_cnt   = '0;
`endif

endmodule

// File: doc/svi_array_driver.md
# svi_array_driver

Drives an array of N_LANES point-to-point interface lanes (x/y signal pairs) with a programmable rotating bit pattern for a programmed number of beats. It is the transmitter for the per-lane clocked sampler modules, whose registered outputs feed back into this block. An optional echo checker compares the fed-back values against what was driven, which gives a self-checking stimulus source for interface-array builds.

## Interface
- N_LANES, 8, number of interface lanes driven.
- PAT_W, 8, pattern width; lane index wraps modulo PAT_W.
- LEN_W, 8, width of the beat-count and error-count fields.

- i_clk  input  1  sole clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_pat_x  input  PAT_W  x pattern, latched on an accepted start.
- i_pat_y  input  PAT_W  y pattern, latched on an accepted start.
- i_len  input  LEN_W  number of drive beats, latched on an accepted start.
- o_x  output  N_LANES  per-lane x drive, registered.
- o_y  output  N_LANES  per-lane y drive, registered.
- o_busy  output  1  high in DRIVE and FLUSH.
- o_done  output  1  one-cycle completion pulse.
- i_a  input  N_LANES  registered x echo from the lane samplers.
- i_b  input  N_LANES  registered y echo from the lane samplers.
- o_err  output  1  sticky mismatch flag.
- o_err_cnt  output  LEN_W  count of mismatching beats, saturating.

## Operation
- States are IDLE, DRIVE, FLUSH and DONE.
- **Accepted start (IDLE with i_start=1):**
  - Latch the patterns into rotation registers rx and ry.
  - Latch i_len; clear the beat counter, o_err and o_err_cnt.
  - If i_len=0, go to DONE and drive no beats. Otherwise go to DRIVE and drive beat 0 on the same edge.
- **Beat t:**
  - o_x[k] = pat_x[(t+k) mod PAT_W] and o_y[k] = pat_y[(t+k) mod PAT_W].
  - This is implemented as rx/ry rotating right by one bit per beat, with lane k reading bit (k mod PAT_W).
  - The rotation wraps every PAT_W beats with no gap.
- **Idle drive value:** o_x = all zeros, o_y = all ones. This applies outside DRIVE, including in FLUSH and DONE.
- **DRIVE:** after beat i_len-1, go to FLUSH.
- **FLUSH:** lasts exactly one cycle, then go to DONE.
- **DONE:** o_done=1 for one cycle, then go to IDLE.
- i_start outside IDLE is ignored. This includes DONE.
- **Echo checker:**
  - The expected value is the previous-cycle o_x/o_y, qualified by a one-cycle-delayed drive-valid flag.
  - Each qualified cycle compares i_a against expected x and i_b against expected y.
  - Any lane mismatch sets o_err and increments o_err_cnt by 1 per beat, not per lane.
  - o_err_cnt saturates at all ones.
- **Reset (any time, including mid-DRIVE):** state IDLE, o_x=0, o_y=all ones, o_busy=0, o_done=0, o_err=0, o_err_cnt=0, beat counter=0. The check pipeline is cleared, so no spurious compare occurs after reset.

## Timing
- Let E0 be the edge that accepts a start. Beat t is visible on o_x/o_y from edge E0+t.
- The lane sampler's registered echo of beat t is valid from E0+t+1. It is compared at E0+t+2.
- o_busy rises at E0 and falls at E0+len+1.
- o_done is high in the cycle after E0+len+1.
- The last beat's compare lands on edge E0+len+1, which is the edge leaving FLUSH. o_err/o_err_cnt are therefore final when o_done is high.
- For i_len=0, o_done is high in the cycle after E0 and o_busy stays 0.
- Back-to-back runs: the earliest next accepted start is the edge after DONE.

## Configuration
- The macro SVI_DRV_CHECK_EN controls the echo checker.
- **Defined:** the echo checker is compiled in as described above.
- **Undefined:**
  - The checker logic is removed.
  - i_a and i_b remain as ports but are unused.
  - o_err is tied to 0 and o_err_cnt to 0.
  - State sequencing, FLUSH length and o_done timing are identical in both builds.

## Test plan
- **Reset values:** assert i_rst_n=0 asynchronously mid-cycle -> immediately o_x=8'h00, o_y=8'hFF, o_busy=0, o_done=0, o_err=0, o_err_cnt=0.
- **Basic run:** pat_x=8'h01, pat_y=8'hFE, len=3, eight registered loopback samplers attached.
  - Required o_x sequence: 8'h01, 8'h80, 8'h40.
  - Required o_y sequence: 8'hFE, 8'h7F, 8'hBF.
  - Then idle values, o_done in the cycle after E0+4, o_err=0.
- **Wrap:** pat_x=8'h01, len=10 -> beat 8 o_x=8'h01, beat 9 o_x=8'h80, err_cnt=0.
- **Fault injection:** i_a[3] stuck at 0, pat_x=8'hFF, len=4 -> o_err=1 after E0+2, o_err_cnt=4 at o_done.
- **Zero length:** len=0 -> o_done in the cycle after E0, o_busy never 1, o_x stays 8'h00.
- **Abort and ignored start:**
  - Pulse i_start during DRIVE beat 1 -> ignored.
  - Assert reset at beat 2 -> reset values.
  - A new start with len=2 completes normally, with o_err_cnt cleared and equal to 0.
